// File: rtl/led_event_pkg.sv
// Shared state encoding and counter sizing for the LED event driver.
package led_event_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLASH = 2'd1,
        GAP   = 2'd2
    } led_state_t;

    // Counter must hold the larger of the flash and gap reload values.
    function automatic int cnt_width(input int flash_ticks, input int gap_ticks);
        int max_ticks;
        max_ticks = (flash_ticks > gap_ticks) ? flash_ticks : gap_ticks;
        return $clog2(max_ticks + 1);
    endfunction

endpackage

// File: rtl/led_event_chan.sv
// One LED channel: IDLE/FLASH/GAP machine timed by the shared tick; LED_EVT_QUEUE_EN adds a pend flag.
// Latency: state_nxt is combinational so the top can register LED/BUSY on the sampling edge.
// Backpressure: none; events during GAP are queued (pend) or dropped.
module led_event_chan
    import led_event_pkg::*;
#(
    parameter int FLASH_TICKS = 100,
    parameter int GAP_TICKS   = 50,
    parameter int CW          = cnt_width(FLASH_TICKS, GAP_TICKS)
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       tick,
    input  logic       ev,
    output led_state_t state_nxt
);

    localparam logic [CW-1:0] FLASH_CNT = CW'(FLASH_TICKS);
    localparam logic [CW-1:0] GAP_CNT   = CW'(GAP_TICKS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    led_state_t    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          last_tick;
    logic          gap_restart;

`ifdef LED_EVT_QUEUE_EN
    logic pend;
    logic pend_nxt;
    assign gap_restart = ev | pend;
`else
    assign gap_restart = ev;
`endif

    // Terminal tick: cnt would reach zero; also guards against underflow.
    assign last_tick = tick && (cnt <= CNT_ONE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
`ifdef LED_EVT_QUEUE_EN
        pend_nxt  = pend;
`endif
        case (state)
            IDLE: begin
                if (ev) begin
                    state_nxt = FLASH;
                    cnt_nxt   = FLASH_CNT;
                end
            end
            FLASH: begin
                if (ev) begin
                    cnt_nxt = FLASH_CNT;
                end else if (last_tick) begin
                    if (GAP_TICKS == 0) state_nxt = IDLE;
                    else                state_nxt = GAP;
                    cnt_nxt = GAP_CNT;
                end else if (tick) begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (last_tick) begin
                    if (gap_restart) begin
                        state_nxt = FLASH;
                        cnt_nxt   = FLASH_CNT;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
`ifdef LED_EVT_QUEUE_EN
                    pend_nxt = 1'b0;
`endif
                end else begin
                    if (tick) cnt_nxt = cnt - 1'b1;
`ifdef LED_EVT_QUEUE_EN
                    if (ev) pend_nxt = 1'b1;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= '0;
`ifdef LED_EVT_QUEUE_EN
            pend  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
`ifdef LED_EVT_QUEUE_EN
            pend  <= pend_nxt;
`endif
        end
    end

endmodule

// File: rtl/led_event_driver.sv
// Front-panel LED driver: shared tick prescaler plus N_CH flash channels (LED_EVT_QUEUE_EN queues gap events).
// Latency: EVENT/LEVEL sampled at an edge appear on LED/BUSY right after that edge.
// Backpressure: none; inputs are accepted every cycle.
module led_event_driver
    import led_event_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int TICK_DIV    = 50000,
    parameter int FLASH_TICKS = 100,
    parameter int GAP_TICKS   = 50
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    input  logic [N_CH-1:0] EVENT,
    input  logic [N_CH-1:0] LEVEL,
    output logic [N_CH-1:0] LED,
    output logic [N_CH-1:0] BUSY
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam int            CW         = cnt_width(FLASH_TICKS, GAP_TICKS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]   presc;
    logic            tick;
    logic [N_CH-1:0] flash_nxt;
    logic [N_CH-1:0] busy_nxt;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)  presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        led_state_t st_nxt;

        led_event_chan #(
            .FLASH_TICKS (FLASH_TICKS),
            .GAP_TICKS   (GAP_TICKS),
            .CW          (CW)
        ) u_chan (
            .CLOCK     (CLOCK),
            .RESET_N   (RESET_N),
            .tick      (tick),
            .ev        (EVENT[i]),
            .state_nxt (st_nxt)
        );

        assign flash_nxt[i] = (st_nxt == FLASH);
        assign busy_nxt[i]  = (st_nxt != IDLE);
    end

    // Registering from next-state keeps LED/BUSY aligned with the sampling edge.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            LED  <= '0;
            BUSY <= '0;
        end else begin
            LED  <= LEVEL ^ flash_nxt;
            BUSY <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_led_event_driver.sv
// Directed bench for led_event_driver; expected LED/BUSY per edge are queued and checked after each edge.
module tb_led_event_driver;

    localparam int N_CH        = 4;
    localparam int TICK_DIV    = 4;
    localparam int FLASH_TICKS = 3;
    localparam int GAP_TICKS   = 2;
    localparam int GAP_LEN     = GAP_TICKS * TICK_DIV;

    logic            CLOCK   = 1'b0;
    logic            RESET_N = 1'b0;
    logic [N_CH-1:0] EVENT   = '0;
    logic [N_CH-1:0] LEVEL   = '0;
    logic [N_CH-1:0] LED;
    logic [N_CH-1:0] BUSY;

    typedef struct {
        int              e;
        string           tag;
        logic [N_CH-1:0] mask;
        logic [N_CH-1:0] led;
        logic [N_CH-1:0] busy;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    led_event_driver #(
        .N_CH        (N_CH),
        .TICK_DIV    (TICK_DIV),
        .FLASH_TICKS (FLASH_TICKS),
        .GAP_TICKS   (GAP_TICKS)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .EVENT   (EVENT),
        .LEVEL   (LEVEL),
        .LED     (LED),
        .BUSY    (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    // Tick edges are the multiples of TICK_DIV counted from reset release;
    // a flash entered at edge e ends on the FLASH_TICKS-th tick edge after e.
    function automatic int flash_end(input int e);
        return (e / TICK_DIV) * TICK_DIV + FLASH_TICKS * TICK_DIV;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_range(input int e0, input int e1, input string tag,
                              input logic [N_CH-1:0] mask, input logic [N_CH-1:0] led,
                              input logic [N_CH-1:0] busy);
        exp_t x;
        for (int e = e0; e <= e1; e++) begin
            x.e    = e;
            x.tag  = tag;
            x.mask = mask;
            x.led  = led;
            x.busy = busy;
            sb.push_back(x);
        end
    endtask

    task automatic drain();
        exp_t keep[$];
        foreach (sb[i]) begin
            if (sb[i].e == cyc) begin
                check($sformatf("%s_led@%0d", sb[i].tag, cyc), 32'(LED & sb[i].mask), 32'(sb[i].led & sb[i].mask));
                check($sformatf("%s_busy@%0d", sb[i].tag, cyc), 32'(BUSY & sb[i].mask), 32'(sb[i].busy & sb[i].mask));
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
        cyc++;
        drain();
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic pulse(input logic [N_CH-1:0] m);
        EVENT = m;
        step();
        EVENT = '0;
    endtask

    initial begin
        int e;
        int fe;
        int fe2;

        // Reset with LEVEL set: outputs held low.
        LEVEL = 4'b1010;
        repeat (3) @(posedge CLOCK);
        #1;
        check("rst_led", 32'(LED), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        RESET_N = 1'b1;
        cyc = 0;
        push_range(1, 1, "rel", 4'hF, 4'b1010, 4'b0000);
        step();
        LEVEL = 4'b0000;
        push_range(2, 2, "lvl0", 4'hF, 4'b0000, 4'b0000);
        step();

        // Basic flash on channel 0.
        e = cyc + 1;
        fe = flash_end(e);
        push_range(e, fe - 1, "b_flash", 4'b0001, 4'b0001, 4'b0001);
        push_range(fe, fe + GAP_LEN - 1, "b_gap", 4'b0001, 4'b0000, 4'b0001);
        push_range(fe + GAP_LEN, fe + GAP_LEN, "b_idle", 4'b0001, 4'b0000, 4'b0000);
        push_range(e, fe + GAP_LEN, "b_other", 4'b1110, 4'b0000, 4'b0000);
        pulse(4'b0001);
        run_to(fe + GAP_LEN);

        // Inverted flash with retrigger on channel 1.
        LEVEL = 4'b0010;
        push_range(cyc + 1, cyc + 1, "inv_lvl", 4'hF, 4'b0010, 4'b0000);
        step();
        e = cyc + 1;
        fe2 = flash_end(e + 6);
        push_range(e, fe2 - 1, "r_flash", 4'b0010, 4'b0000, 4'b0010);
        push_range(fe2, fe2 + GAP_LEN - 1, "r_gap", 4'b0010, 4'b0010, 4'b0010);
        push_range(fe2 + GAP_LEN, fe2 + GAP_LEN, "r_idle", 4'b0010, 4'b0010, 4'b0000);
        push_range(e, fe2 + GAP_LEN, "r_other", 4'b1101, 4'b0000, 4'b0000);
        pulse(4'b0010);
        run_to(e + 5);
        pulse(4'b0010);
        run_to(fe2 + GAP_LEN);

        // Event two cycles into the gap on channel 2.
        LEVEL = 4'b0000;
        push_range(cyc + 1, cyc + 1, "g_lvl", 4'hF, 4'b0000, 4'b0000);
        step();
        e = cyc + 1;
        fe = flash_end(e);
        push_range(e, fe - 1, "g_flash", 4'b0100, 4'b0100, 4'b0100);
        push_range(fe, fe + GAP_LEN - 1, "g_gap", 4'b0100, 4'b0000, 4'b0100);
`ifdef LED_EVT_QUEUE_EN
        fe2 = flash_end(fe + GAP_LEN);
        push_range(fe + GAP_LEN, fe2 - 1, "g_flash2", 4'b0100, 4'b0100, 4'b0100);
        push_range(fe2, fe2 + GAP_LEN - 1, "g_gap2", 4'b0100, 4'b0000, 4'b0100);
        push_range(fe2 + GAP_LEN, fe2 + GAP_LEN, "g_idle", 4'b0100, 4'b0000, 4'b0000);
        fe2 = fe2 + GAP_LEN;
`else
        fe2 = fe + GAP_LEN + 2 * TICK_DIV;
        push_range(fe + GAP_LEN, fe2, "g_drop", 4'b0100, 4'b0000, 4'b0000);
`endif
        push_range(e, fe2, "g_other", 4'b1011, 4'b0000, 4'b0000);
        pulse(4'b0100);
        run_to(fe + 1);
        pulse(4'b0100);
        run_to(fe2);

        // Event coincident with the terminal gap tick on channel 3.
        step();
        e = cyc + 1;
        fe = flash_end(e);
        fe2 = flash_end(fe + GAP_LEN);
        push_range(e, fe - 1, "c_flash", 4'b1000, 4'b1000, 4'b1000);
        push_range(fe, fe + GAP_LEN - 1, "c_gap", 4'b1000, 4'b0000, 4'b1000);
        push_range(fe + GAP_LEN, fe2 - 1, "c_flash2", 4'b1000, 4'b1000, 4'b1000);
        push_range(fe2, fe2 + GAP_LEN - 1, "c_gap2", 4'b1000, 4'b0000, 4'b1000);
        push_range(fe2 + GAP_LEN, fe2 + GAP_LEN, "c_idle", 4'b1000, 4'b0000, 4'b0000);
        push_range(e, fe2 + GAP_LEN, "c_other", 4'b0111, 4'b0000, 4'b0000);
        pulse(4'b1000);
        run_to(fe + GAP_LEN - 1);
        pulse(4'b1000);
        run_to(fe2 + GAP_LEN);

        // All channels at once: identical waveforms.
        step();
        e = cyc + 1;
        fe = flash_end(e);
        push_range(e, fe - 1, "all_flash", 4'hF, 4'hF, 4'hF);
        push_range(fe, fe + GAP_LEN - 1, "all_gap", 4'hF, 4'h0, 4'hF);
        push_range(fe + GAP_LEN, fe + GAP_LEN, "all_idle", 4'hF, 4'h0, 4'h0);
        pulse(4'hF);
        run_to(fe + GAP_LEN + 1);

        // Reset asserted mid-flash on channels 0 and 3.
        e = cyc + 1;
        push_range(e, e + 2, "m_flash", 4'hF, 4'b1001, 4'b1001);
        pulse(4'b1001);
        run_to(e + 3);
        RESET_N = 1'b0;
        #1;
        check("mrst_led", 32'(LED), 32'h0);
        check("mrst_busy", 32'(BUSY), 32'h0);
        repeat (2) @(posedge CLOCK);
        #1;
        check("mrst_hold_led", 32'(LED), 32'h0);
        RESET_N = 1'b1;
        cyc = 0;
        push_range(1, 1, "p_rel", 4'hF, 4'h0, 4'h0);
        step();
        e = cyc + 1;
        fe = flash_end(e);
        push_range(e, fe - 1, "p_flash", 4'b0001, 4'b0001, 4'b0001);
        push_range(fe, fe + GAP_LEN - 1, "p_gap", 4'b0001, 4'b0000, 4'b0001);
        push_range(fe + GAP_LEN, fe + GAP_LEN, "p_idle", 4'b0001, 4'b0000, 4'b0000);
        push_range(e, fe + GAP_LEN, "p_other", 4'b1110, 4'b0000, 4'b0000);
        pulse(4'b0001);
        run_to(fe + GAP_LEN);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
